// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: ready/valid pipeline register carrying instr, PC+8 and immediate, with optional 2-entry skid and stall/bubble counters
module pipe_stage_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int IMM_W   = 16,
    parameter int SKID    = 0,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc8_i,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc8_o,
    output logic [IMM_W-1:0]   imm_o,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_n;
    logic [INSTR_W-1:0] instr_n, skid_instr, skid_instr_n;
    logic [PC_W-1:0]    pc8_n, skid_pc8, skid_pc8_n;
    logic [IMM_W-1:0]   imm_n, skid_imm, skid_imm_n;
    logic               rdy_q, in_xfer, out_xfer;
    // Without a skid slot the stage can never reach TWO: in_ready blocks input while a held head is stalled.
    assign out_valid = state != EMPTY;
    assign in_ready  = SKID != 0 ? rdy_q : (out_ready || !out_valid);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    always_comb begin
        state_n      = state;
        instr_n      = instr_o;
        pc8_n        = pc8_o;
        imm_n        = imm_o;
        skid_instr_n = skid_instr;
        skid_pc8_n   = skid_pc8;
        skid_imm_n   = skid_imm;
        if (flush) begin
            state_n      = EMPTY;
            instr_n      = '0;
            pc8_n        = '0;
            imm_n        = '0;
            skid_instr_n = '0;
            skid_pc8_n   = '0;
            skid_imm_n   = '0;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    state_n = ONE;
                    instr_n = instr_i;
                    pc8_n   = pc8_i;
                    imm_n   = instr_i[IMM_W-1:0];
                end
                ONE: if (in_xfer && out_xfer) begin
                    instr_n = instr_i;
                    pc8_n   = pc8_i;
                    imm_n   = instr_i[IMM_W-1:0];
                end else if (in_xfer) begin
                    state_n      = TWO;
                    skid_instr_n = instr_i;
                    skid_pc8_n   = pc8_i;
                    skid_imm_n   = instr_i[IMM_W-1:0];
                end else if (out_xfer) begin
                    state_n = EMPTY;
                    instr_n = '0;
                    pc8_n   = '0;
                    imm_n   = '0;
                end
                TWO: if (out_xfer) begin
                    state_n      = ONE;
                    instr_n      = skid_instr;
                    pc8_n        = skid_pc8;
                    imm_n        = skid_imm;
                    skid_instr_n = '0;
                    skid_pc8_n   = '0;
                    skid_imm_n   = '0;
                end
                default: state_n = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY;
            rdy_q      <= 1'b1;
            instr_o    <= '0;
            pc8_o      <= '0;
            imm_o      <= '0;
            skid_instr <= '0;
            skid_pc8   <= '0;
            skid_imm   <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            state      <= state_n;
            rdy_q      <= state_n != TWO;
            instr_o    <= instr_n;
            pc8_o      <= pc8_n;
            imm_o      <= imm_n;
            skid_instr <= skid_instr_n;
            skid_pc8   <= skid_pc8_n;
            skid_imm   <= skid_imm_n;
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid && out_ready && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
endmodule
